// File: rtl/pcm_mem_arbiter.sv
// Round-robin arbiter sharing the single 16-bit PCM memory port among NUM_CPU cores.
// Define PCM_ARB_STATS_EN to add per-core grant counters and an IDLE conflict counter.
module pcm_mem_arbiter #(
    parameter int NUM_CPU = 4,
    parameter int MEM_AW  = 11,
    parameter int CPU_AW  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CPU-1:0]        cpu_ce_n,
    input  logic [NUM_CPU-1:0]        cpu_oe_n,
    input  logic [NUM_CPU-1:0]        cpu_we_n,
    input  logic [NUM_CPU*CPU_AW-1:0] cpu_addr,
    input  logic [NUM_CPU*16-1:0]     cpu_wdata,
    output logic [NUM_CPU*16-1:0]     cpu_rdata,
    output logic [NUM_CPU-1:0]        cpu_ready,
    output logic [NUM_CPU-1:0]        cpu_addr_err,
    output logic [MEM_AW-1:0]         mem_address,
    output logic                      mem_chipselect,
    output logic                      mem_clken,
    output logic                      mem_write,
    output logic [15:0]               mem_writedata,
    output logic [1:0]                mem_byteenable,
`ifdef PCM_ARB_STATS_EN
    output logic [NUM_CPU*16-1:0]     grant_cnt,
    output logic [15:0]               conflict_cnt,
`endif
    input  logic [15:0]               mem_readdata
);
    localparam int IW = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t                   r_state;
    logic [IW-1:0]            r_grant;
    logic [IW-1:0]            r_rr;
    logic                     r_is_write;
    logic                     r_err;
    logic [NUM_CPU-1:0][15:0] r_rdata;
    logic [NUM_CPU-1:0]       r_ready;
    logic [NUM_CPU-1:0]       r_addr_err;
    logic [MEM_AW-1:0]        r_mem_address;
    logic                     r_mem_chipselect;
    logic                     r_mem_write;
    logic [15:0]              r_mem_writedata;

    logic [NUM_CPU-1:0]       w_req;
    logic                     w_any;
    logic [IW-1:0]            w_pick;
    logic [CPU_AW-1:0]        w_sel_addr;
    logic [15:0]              w_sel_wdata;
    logic                     w_sel_we;
    logic                     w_sel_err;

    assign w_req = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n);

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NUM_CPU; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_CPU) idx = idx - NUM_CPU;
            if (!w_any && w_req[idx]) begin
                w_any  = 1'b1;
                w_pick = IW'(idx);
            end
        end
    end

    assign w_sel_addr  = cpu_addr[int'(w_pick)*CPU_AW +: CPU_AW];
    assign w_sel_wdata = cpu_wdata[int'(w_pick)*16 +: 16];
    assign w_sel_we    = ~cpu_we_n[w_pick];
    assign w_sel_err   = |w_sel_addr[CPU_AW-1:MEM_AW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_grant          <= '0;
            r_rr             <= '0;
            r_is_write       <= 1'b0;
            r_err            <= 1'b0;
            r_rdata          <= '0;
            r_ready          <= '0;
            r_addr_err       <= '0;
            r_mem_address    <= '0;
            r_mem_chipselect <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_writedata  <= '0;
        end else begin
            r_ready <= '0;
            case (r_state)
                IDLE: begin
                    r_mem_chipselect <= 1'b0;
                    r_mem_write      <= 1'b0;
                    if (w_any) begin
                        // Mem strobes are loaded here so they are live during ISSUE.
                        r_grant          <= w_pick;
                        r_is_write       <= w_sel_we;
                        r_err            <= w_sel_err;
                        r_mem_address    <= w_sel_addr[MEM_AW-1:0];
                        r_mem_writedata  <= w_sel_wdata;
                        r_mem_chipselect <= ~w_sel_err;
                        r_mem_write      <= w_sel_we & ~w_sel_err;
                        if (w_sel_err) r_addr_err[w_pick] <= 1'b1;
                        r_state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_chipselect <= 1'b0;
                    r_mem_write      <= 1'b0;
                    r_state          <= RESP;
                end
                RESP: begin
                    if (!r_is_write) r_rdata[r_grant] <= r_err ? 16'h0000 : mem_readdata;
                    r_ready[r_grant] <= 1'b1;
                    r_state          <= DONE;
                end
                DONE: begin
                    r_rr    <= (int'(r_grant) == NUM_CPU - 1) ? '0 : r_grant + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_rdata      = r_rdata;
    assign cpu_ready      = r_ready;
    assign cpu_addr_err   = r_addr_err;
    assign mem_address    = r_mem_address;
    assign mem_chipselect = r_mem_chipselect;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;
    assign mem_clken      = 1'b1;
    assign mem_byteenable = 2'b11;

`ifdef PCM_ARB_STATS_EN
    logic [NUM_CPU-1:0][15:0] r_grant_cnt;
    logic [15:0]              r_conflict_cnt;
    logic                     w_multi_req;

    assign w_multi_req = (w_req & (w_req - NUM_CPU'(1))) != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (r_state == DONE && r_grant_cnt[r_grant] != 16'hFFFF)
                r_grant_cnt[r_grant] <= r_grant_cnt[r_grant] + 16'd1;
            if (r_state == IDLE && w_multi_req && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign grant_cnt    = r_grant_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif
endmodule

// File: doc/pcm_mem_arbiter.md
Name: pcm_mem_arbiter

Overview:
Round-robin arbiter that shares the single 16-bit on-chip PCM memory Avalon-MM slave port among NUM_CPU CPU cores. Each core uses its native strobes: active-low CE/OE/WE, 20-bit address and 16-bit data.
- Sits between the CPU instances and the pcm_mem_mm conduit.
- Serialises accesses to that port.
- Returns read data and a one-cycle ready pulse to each core.

Parameters:
NUM_CPU, 4, number of requesting cores (2..8)
MEM_AW, 11, memory word-address width; CPU address bits [19:MEM_AW] must be zero
CPU_AW, 20, CPU address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_ce_n  in  NUM_CPU  per-core chip enable, active low
cpu_oe_n  in  NUM_CPU  per-core output enable (read), active low
cpu_we_n  in  NUM_CPU  per-core write enable, active low
cpu_addr  in  NUM_CPU*CPU_AW  packed addresses, core i at [i*CPU_AW +: CPU_AW]
cpu_wdata  in  NUM_CPU*16  packed write data
cpu_rdata  out  NUM_CPU*16  packed registered read data
cpu_ready  out  NUM_CPU  one-cycle completion pulse per core
cpu_addr_err  out  NUM_CPU  sticky out-of-range flag per core
mem_address  out  MEM_AW  to pcm_mem_mm.address
mem_chipselect  out  1  to pcm_mem_mm.chipselect
mem_clken  out  1  to pcm_mem_mm.clken; tied 1
mem_write  out  1  to pcm_mem_mm.write, active high
mem_writedata  out  16  to pcm_mem_mm.writedata
mem_byteenable  out  2  to pcm_mem_mm.byteenable; tied 2'b11
mem_readdata  in  16  from pcm_mem_mm.readdata; fixed read latency 1

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values: cpu_rdata=0, cpu_ready=0, cpu_addr_err=0, mem_address=0, mem_chipselect=0, mem_write=0, mem_writedata=0, rr pointer=0, state=IDLE.
- Request decode:
  - req[i] = ~cpu_ce_n[i] & (~cpu_oe_n[i] | ~cpu_we_n[i]).
  - Write wins if OE_n and WE_n are both low.
- FSM states: IDLE, ISSUE, RESP, DONE.
- IDLE:
  - If any req is set, pick the first requester at or after rr_ptr, wrapping modulo NUM_CPU.
  - Register grant index, address, write flag and wdata, then go to ISSUE.
  - With no requests, stay in IDLE with all mem outputs deasserted.
- ISSUE (1 cycle):
  - Drive mem_chipselect=1, mem_address=addr[MEM_AW-1:0], mem_write=is_write, mem_writedata=wdata.
  - If latched addr[CPU_AW-1:MEM_AW] is nonzero: force chipselect=0 and write=0, and set cpu_addr_err[grant].
  - Go to RESP.
- RESP (1 cycle):
  - mem outputs deasserted.
  - On a read with valid address, capture mem_readdata into cpu_rdata[grant].
  - On a read with error, load 16'h0000.
  - On a write, cpu_rdata is unchanged.
  - Go to DONE.
- DONE (1 cycle):
  - cpu_ready[grant]=1.
  - rr_ptr = (grant+1) mod NUM_CPU.
  - Go to IDLE.
- Latency: a request seen in IDLE in cycle 0 gives ready in cycle 3. Minimum issue spacing is 4 cycles.
- Held requests: a core still asserting its request in the cycle after ready is treated as a new request. Cores must drop CE_n after ready if they want a single access.
- Request withdrawn after IDLE latches it: the access still completes with latched values and ready still pulses.
- Fairness: with all NUM_CPU requesting continuously, grants rotate 0,1,2,3,0,...; no core waits more than NUM_CPU accesses.
- cpu_rdata[i]: holds its value until the next read completion for core i.
- cpu_addr_err: sticky, cleared only by reset.
- Reset mid-operation: the FSM aborts to IDLE asynchronously and mem_write drops immediately. The interrupted core gets no ready pulse.

Optional Feature:
Macro PCM_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt, NUM_CPU*16 bits: one 16-bit saturating counter per core, incremented in DONE for the granted core, reset to 0.
  - Adds output conflict_cnt, 16 bits, saturating: incremented on each IDLE cycle where more than one req is set.
- Not defined: neither port nor the counters exist. Core behaviour is identical either way.

Test Plan:
- Core0 write addr 0x00005 data 0xBEEF; release; core0 read 0x00005 -> mem_write=1 with address 5 in the ISSUE cycle; read ready 3 cycles after request; cpu_rdata[0]=0xBEEF.
- Cores 0..3 request simultaneously, writing 0x1110..0x1113 to addr 0x10..0x13 -> grants in order 0,1,2,3, ready pulses 4 cycles apart; readback returns matching values.
- All 4 cores hold requests continuously for 16 accesses -> each core is granted exactly 4 times; rotation never skips a core.
- Core2 reads addr 0x00800 (bit 11 set) -> no chipselect in ISSUE; cpu_rdata[2]=0x0000; cpu_addr_err[2]=1 and stays set; ready still pulses.
- Assert reset during ISSUE of a core1 write -> mem_write=0 immediately; no cpu_ready[1]; all outputs at reset values; next request is served normally after reset is released.
- Stats build: 5 accesses by core3 plus one 2-way conflict -> grant_cnt[3]=5, conflict_cnt=1; 70000 core0 accesses -> grant_cnt[0] saturates at 0xFFFF.
